int_divider: RTL

Sequential integer divider, the inverse of the `int_multiply_adder` MAC (P = A*B + C). It takes a 64-bit dividend and a 32-bit divisor and returns quotient and remainder such that DIVIDEND = QUOTIENT*DIVISOR + REMAINDER, with REMAINDER < DIVISOR. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on input and output. Its results can be fed straight back into the MAC to reproduce the dividend.

---
 rtl/int_divider_pkg.sv | 22 ++
 rtl/int_divider_if.sv | 43 ++++
 rtl/int_divider_step.sv | 23 ++
 rtl/int_divider.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/int_divider_pkg.sv
// int_div_pkg: FSM state type, default widths and shared constants for the
// int_divider slice (optional signed mode is selected with INT_DIVIDER_SIGNED_EN).
package int_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int WA_DEF = 64;
  localparam int WB_DEF = 32;

  localparam logic [WA_DEF-1:0] DIV0_QUOT = '1;

  function automatic int cnt_width(input int wa);
    return (wa > 1) ? $clog2(wa) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WA_DEF);

endpackage

// File: rtl/int_divider_if.sv
// int_divider_if: operand/result handshake bundle for int_divider.
// The sgn field exists only when INT_DIVIDER_SIGNED_EN is defined.
interface int_divider_if
  import int_div_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] dividend;
  logic [WB-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] quotient;
  logic [WB-1:0] remainder;
  logic          div0;
`ifdef INT_DIVIDER_SIGNED_EN
  logic          sgn;

  modport master (
    output in_valid, dividend, divisor, out_ready, sgn,
    input  in_ready, out_valid, quotient, remainder, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready, sgn,
    output in_ready, out_valid, quotient, remainder, div0
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div0
  );
`endif

endinterface

// File: rtl/int_divider_step.sv
// int_div_step: one radix-2 restoring step. Shifts the next dividend bit into
// the partial remainder and subtracts the divisor when it fits.
module int_div_step
  import int_div_pkg::*;
#(
  parameter int WB = WB_DEF
) (
  input  logic [WB-1:0] i_part,
  input  logic          i_bit,
  input  logic [WB-1:0] i_divisor,
  output logic [WB-1:0] o_part,
  output logic          o_qbit
);

  // The shifted partial is WB+1 bits so the compare can never overflow; the
  // stored partial is always below the divisor and so fits back into WB bits.
  logic [WB:0] w_shift;

  assign w_shift = {i_part, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  assign o_part  = o_qbit ? (w_shift[WB-1:0] - i_divisor) : w_shift[WB-1:0];

endmodule

// File: rtl/int_divider.sv
// int_divider: sequential radix-2 restoring divider, one quotient bit per cycle,
// valid/ready in and out. Define INT_DIVIDER_SIGNED_EN for two's-complement mode.
module int_divider
  import int_div_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WB = WB_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  int_divider_if.slave  bus
);

  localparam int CW = cnt_width(WA);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WA-1:0] r_dvd;
  logic [WB-1:0] r_dvs;
  logic [WB-1:0] r_part;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [WA-1:0] r_quot;
  logic [WB-1:0] r_rem;
  logic          r_div0;

  logic          w_accept;
  logic [WB-1:0] w_part_next;
  logic          w_qbit;
  logic [WA-1:0] w_dvd_mag;
  logic [WB-1:0] w_dvs_mag;
  logic [WA-1:0] w_quot_raw;
  logic [WB-1:0] w_rem_raw;
  logic [WA-1:0] w_quot_fix;
  logic [WB-1:0] w_rem_fix;

  assign w_accept = (r_state == IDLE) && r_in_ready && bus.in_valid;

  int_div_step #(.WB(WB)) u_step (
    .i_part    (r_part),
    .i_bit     (r_dvd[WA-1]),
    .i_divisor (r_dvs),
    .o_part    (w_part_next),
    .o_qbit    (w_qbit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign w_quot_raw = {r_dvd[WA-2:0], w_qbit};
  assign w_rem_raw  = w_part_next;

`ifdef INT_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg = bus.sgn && bus.dividend[WA-1];
  assign w_dvs_neg = bus.sgn && bus.divisor[WB-1];
  assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end

  // Truncating division: quotient negated on sign mismatch, remainder follows dividend.
  assign w_quot_fix = r_neg_q ? -w_quot_raw : w_quot_raw;
  assign w_rem_fix  = r_neg_r ? -w_rem_raw  : w_rem_raw;
`else
  assign w_dvd_mag  = bus.dividend;
  assign w_dvs_mag  = bus.divisor;
  assign w_quot_fix = w_quot_raw;
  assign w_rem_fix  = w_rem_raw;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_part      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_div0      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_part     <= '0;
            r_cnt      <= CW'(WA - 1);
            if (bus.divisor == '0) begin
              // Raw dividend kept: its low bits become the divide-by-zero remainder.
              r_dvd   <= bus.dividend;
              r_dvs   <= '0;
              r_state <= DONE;
            end else begin
              r_dvd   <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_state <= CALC;
            end
          end
        end

        CALC: begin
          r_part <= w_part_next;
          r_dvd  <= w_quot_raw;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quot      <= w_quot_fix;
            r_rem       <= w_rem_fix;
            r_div0      <= 1'b0;
          end
        end

        DONE: begin
          // Only the divide-by-zero path arrives here with results not yet loaded.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_quot      <= WA'(DIV0_QUOT);
            r_rem       <= r_dvd[WB-1:0];
            r_div0      <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.div0      = r_div0;

endmodule
